// File: rtl/bitrev_arbiter_if.sv
// Handshake bundle for bitrev_arbiter: two valid/ready request channels (A, B),
// one tagged result stream and the busy flag.
interface bitrev_arbiter_if #(
  parameter int DW = 4
);
  logic          a_valid;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          out_ready;
  logic          busy;

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_src, busy
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_src, busy
  );
endinterface

// File: rtl/bitrev_arbiter.sv
// Shared bit-order reversal unit arbitrating two requesters onto one tagged,
// registered output stream. BITREV_FIXED_PRIO_EN selects fixed A-first priority.
module bitrev_arbiter #(
  parameter int DW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  bitrev_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t        state_r;
  logic          out_valid_r;
  logic [DW-1:0] out_data_r;
  logic          out_src_r;
  logic          last_src_r;

  logic          can_accept_s;
  logic          grant_a_s;
  logic          grant_b_s;
  logic          accept_s;
  logic [DW-1:0] sel_data_s;

  function automatic logic [DW-1:0] bitrev(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) begin
      r[i] = d[DW-1-i];
    end
    return r;
  endfunction

  // A drain in the same cycle frees the output register, so HOLD can still accept.
  assign can_accept_s = (state_r == ST_IDLE) || bus.out_ready;

  // Grant selection between A and B, only when the output can take a word.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (can_accept_s) begin
      if (bus.a_valid && !bus.b_valid) begin
        grant_a_s = 1'b1;
      end else if (!bus.a_valid && bus.b_valid) begin
        grant_b_s = 1'b1;
      end else if (bus.a_valid && bus.b_valid) begin
`ifdef BITREV_FIXED_PRIO_EN
        grant_a_s = 1'b1;
`else
        if (last_src_r) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
`endif
      end else begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  assign accept_s   = grant_a_s || grant_b_s;
  assign sel_data_s = grant_b_s ? bus.b_data : bus.a_data;

  // Output register FSM: IDLE = empty, HOLD = result held until drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      out_data_r  <= {DW{1'b0}};
      out_src_r   <= 1'b0;
      last_src_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r     <= ST_HOLD;
            out_valid_r <= 1'b1;
            out_data_r  <= bitrev(sel_data_s);
            out_src_r   <= grant_b_s;
            last_src_r  <= grant_b_s;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            if (accept_s) begin
              out_valid_r <= 1'b1;
              out_data_r  <= bitrev(sel_data_s);
              out_src_r   <= grant_b_s;
              last_src_r  <= grant_b_s;
            end else begin
              state_r     <= ST_IDLE;
              out_valid_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_ready   = grant_a_s;
  assign bus.b_ready   = grant_b_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_src   = out_src_r;
  assign bus.busy      = out_valid_r;

endmodule

// File: tb/tb_bitrev_arbiter.sv
// Directed self-checking bench for bitrev_arbiter (DW=4); builds with or
// without BITREV_FIXED_PRIO_EN and expects the matching arbitration.
module tb_bitrev_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bitrev_arbiter_if #(.DW(4)) bus ();

  bitrev_arbiter #(.DW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected source per cycle of the contested run entered with last_src=A.
  logic [3:0] rr_src;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] rev_a;
  logic [3:0] rev_b;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.a_valid   = 1'b0;
    bus.a_data    = 4'b0000;
    bus.b_valid   = 1'b0;
    bus.b_data    = 4'b0000;
    bus.out_ready = 1'b0;
`ifdef BITREV_FIXED_PRIO_EN
    rr_src = 4'b0000;
`else
    rr_src = 4'b0101;   // cycle 0 -> B, 1 -> A, 2 -> B, 3 -> A
`endif

    // Reset values
    #12;
    check_eq("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
    check_eq("rst_out_data",  {4'd0, bus.out_data},  8'd0);
    check_eq("rst_out_src",   {7'd0, bus.out_src},   8'd0);
    check_eq("rst_busy",      {7'd0, bus.busy},      8'd0);
    rst_n = 1'b1;
    tick();

    // Single request from A
    bus.a_valid   = 1'b1;
    bus.a_data    = 4'b0001;
    bus.out_ready = 1'b1;
    #1;
    check_eq("single_a_ready", {7'd0, bus.a_ready}, 8'd1);
    check_eq("single_b_ready", {7'd0, bus.b_ready}, 8'd0);
    tick();
    bus.a_valid = 1'b0;
    check_eq("single_out_valid", {7'd0, bus.out_valid}, 8'd1);
    check_eq("single_out_data",  {4'd0, bus.out_data},  8'h08);
    check_eq("single_out_src",   {7'd0, bus.out_src},   8'd0);
    check_eq("single_busy",      {7'd0, bus.busy},      8'd1);
    tick();
    check_eq("drain_out_valid", {7'd0, bus.out_valid}, 8'd0);
    check_eq("drain_busy",      {7'd0, bus.busy},      8'd0);

    // Contention: last grant was A, so round-robin starts with B
    in_a  = 4'b0011; rev_a = 4'b1100;
    in_b  = 4'b0110; rev_b = 4'b0110;
    bus.a_valid = 1'b1; bus.a_data = in_a;
    bus.b_valid = 1'b1; bus.b_data = in_b;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("rr_a_ready", {7'd0, bus.a_ready}, {7'd0, ~rr_src[k]});
      check_eq("rr_b_ready", {7'd0, bus.b_ready}, {7'd0, rr_src[k]});
      tick();
      check_eq("rr_out_valid", {7'd0, bus.out_valid}, 8'd1);
      check_eq("rr_out_src",   {7'd0, bus.out_src},   {7'd0, rr_src[k]});
      check_eq("rr_out_data",  {4'd0, bus.out_data},  {4'd0, (rr_src[k] ? rev_b : rev_a)});
    end

    // Backpressure: load 1010 from A, then stall five cycles
    bus.b_valid = 1'b0;
    bus.a_data  = 4'b0101;
    tick();
    check_eq("bp_load_data", {4'd0, bus.out_data}, 8'h0A);
    bus.out_ready = 1'b0;
    bus.a_data    = 4'b0111;
    bus.b_valid   = 1'b1;
    bus.b_data    = 4'b1110;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("bp_a_ready", {7'd0, bus.a_ready}, 8'd0);
      check_eq("bp_b_ready", {7'd0, bus.b_ready}, 8'd0);
      tick();
      check_eq("bp_out_valid", {7'd0, bus.out_valid}, 8'd1);
      check_eq("bp_out_data",  {4'd0, bus.out_data},  8'h0A);
      check_eq("bp_out_src",   {7'd0, bus.out_src},   8'd0);
    end
    // Release: drain and load the next word in the same edge (last_src=A -> B wins)
    bus.out_ready = 1'b1;
    #1;
`ifdef BITREV_FIXED_PRIO_EN
    check_eq("bp_rel_a_ready", {7'd0, bus.a_ready}, 8'd1);
    tick();
    check_eq("bp_rel_out_data", {4'd0, bus.out_data}, 8'h0E);
    check_eq("bp_rel_out_src",  {7'd0, bus.out_src},  8'd0);
`else
    check_eq("bp_rel_b_ready", {7'd0, bus.b_ready}, 8'd1);
    tick();
    check_eq("bp_rel_out_data", {4'd0, bus.out_data}, 8'h07);
    check_eq("bp_rel_out_src",  {7'd0, bus.out_src},  8'd1);
    // Only A now: last_src becomes A so reset must restore A-first
    bus.b_valid = 1'b0;
    tick();
    check_eq("a_only_out_src",  {7'd0, bus.out_src},  8'd0);
    check_eq("a_only_out_data", {4'd0, bus.out_data}, 8'h0E);
`endif

    // Reset mid-operation with a result held
    bus.a_valid   = 1'b0;
    bus.b_valid   = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {7'd0, bus.out_valid}, 8'd0);
    check_eq("midrst_out_data",  {4'd0, bus.out_data},  8'd0);
    check_eq("midrst_busy",      {7'd0, bus.busy},      8'd0);
    #2;
    rst_n = 1'b1;
    tick();
    bus.a_valid = 1'b1; bus.a_data = 4'b0111;
    bus.b_valid = 1'b1; bus.b_data = 4'b0001;
    bus.out_ready = 1'b1;
    #1;
    check_eq("postrst_a_ready", {7'd0, bus.a_ready}, 8'd1);
    check_eq("postrst_b_ready", {7'd0, bus.b_ready}, 8'd0);
    tick();
    check_eq("postrst_out_src",  {7'd0, bus.out_src},  8'd0);
    check_eq("postrst_out_data", {4'd0, bus.out_data}, 8'h0E);

`ifdef BITREV_FIXED_PRIO_EN
    // Fixed priority: A wins every contested cycle
    bus.a_data = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("fp_b_ready", {7'd0, bus.b_ready}, 8'd0);
      tick();
      check_eq("fp_out_src",  {7'd0, bus.out_src},  8'd0);
      check_eq("fp_out_data", {4'd0, bus.out_data}, 8'h0C);
    end
`endif

    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
